// File: rtl/icn_pkg.sv
// rtl/icn_pkg.sv - shared types and helpers for the read-channel interconnect
package icn_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axi_resp_t;

    // Index width for a table of n entries; never narrower than one bit
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ICN_DEF_MAX_OUT = 2;
    localparam int ICN_DEF_PTR_W   = ptr_w(ICN_DEF_MAX_OUT);

endpackage

// File: rtl/icn_rr_arb.sv
// rtl/icn_rr_arb.sv - combinational N-way round-robin grant
module icn_rr_arb
    import icn_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = ptr_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    // Scan last+1, last+2, ... (mod N) and grant the first requester found
    always_comb begin
        logic          found;
        logic [IW-1:0] k;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 1; i <= N; i++) begin
            k = IW'((int'(last_i) + i) % N);
            if (!found && req_i[k]) begin
                found    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = k;
            end
        end
    end

endmodule

// File: rtl/icn_rd_arb.sv
// rtl/icn_rd_arb.sv - N-master to 1-slave AXI-lite read interconnect with in-order route FIFO
module icn_rd_arb
    import icn_pkg::*;
#(
    parameter int N_MST   = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_MST-1:0]          m_ar_valid,
    input  logic [N_MST*ADDR_W-1:0]   m_ar_addr,
    output logic [N_MST-1:0]          m_ar_ready,
    output logic [N_MST-1:0]          m_r_valid,
    output logic [DATA_W-1:0]         m_r_data,
    output logic [1:0]                m_r_resp,
    input  logic [N_MST-1:0]          m_r_ready,
    output logic                      s_ar_valid,
    output logic [ADDR_W-1:0]         s_ar_addr,
    input  logic                      s_ar_ready,
    input  logic                      s_r_valid,
    input  logic [DATA_W-1:0]         s_r_data,
    input  logic [1:0]                s_r_resp,
    output logic                      s_r_ready
);

    localparam int IW = ptr_w(N_MST);
    localparam int AW = ptr_w(MAX_OUT);
    localparam int CW = $clog2(MAX_OUT + 1);

    // AR register, RR pointer, route FIFO and outstanding count
    logic              ar_full_q, ar_full_d;
    logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
    logic [IW-1:0]     last_q, last_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [IW-1:0]     route_q [MAX_OUT];
    logic [IW-1:0]     route_d [MAX_OUT];

    logic [N_MST-1:0]  gnt;
    logic [IW-1:0]     gnt_idx;
    logic [ADDR_W-1:0] gnt_addr;
    logic [IW-1:0]     head;
    logic              acc_ok;
    logic              push;
    logic              pop;
    logic              fifo_empty;

    // Index wraps modulo MAX_OUT; the top bit flips on every wrap so full and
    // empty stay distinguishable even when MAX_OUT is not a power of two
    function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
        if (p[AW-1:0] == AW'(MAX_OUT - 1)) begin
            return {~p[AW], {AW{1'b0}}};
        end
        return p + 1'b1;
    endfunction

    icn_rr_arb #(
        .N  (N_MST),
        .IW (IW)
    ) u_rr_arb (
        .req_i  (m_ar_valid),
        .last_i (last_q),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx)
    );

    // AR acceptance: registered count only, so a same-cycle R pop never opens a slot
    always_comb begin
        acc_ok     = !rst_i && (!ar_full_q || s_ar_ready) && (cnt_q < CW'(MAX_OUT));
        push       = acc_ok && (|m_ar_valid);
        m_ar_ready = push ? gnt : '0;
        gnt_addr   = '0;
        for (int k = 0; k < N_MST; k++) begin
            if (gnt[k]) begin
                gnt_addr = m_ar_addr[k*ADDR_W +: ADDR_W];
            end
        end
    end

    // R routing: the FIFO head names the master owed the next in-order response
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        head       = route_q[rd_ptr_q[AW-1:0]];
        m_r_valid  = '0;
        s_r_ready  = 1'b0;
        if (!fifo_empty) begin
            for (int k = 0; k < N_MST; k++) begin
                if (head == IW'(k)) begin
                    m_r_valid[k] = s_r_valid;
                    s_r_ready    = m_r_ready[k];
                end
            end
        end
        pop      = s_r_valid && s_r_ready;
        m_r_data = s_r_data;
        m_r_resp = s_r_resp;
    end

    // Slave AR side is driven straight from the register
    always_comb begin
        s_ar_valid = ar_full_q;
        s_ar_addr  = ar_addr_q;
    end

    // Next-state for AR register, pointer, FIFO and count
    always_comb begin
        ar_full_d = ar_full_q;
        ar_addr_d = ar_addr_q;
        last_d    = last_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        route_d   = route_q;
        cnt_d     = cnt_q + CW'(push) - CW'(pop);

        if (push) begin
            ar_full_d                = 1'b1;
            ar_addr_d                = gnt_addr;
            last_d                   = gnt_idx;
            route_d[wr_ptr_q[AW-1:0]] = gnt_idx;
            wr_ptr_d                 = ptr_inc(wr_ptr_q);
        end else if (ar_full_q && s_ar_ready) begin
            ar_full_d = 1'b0;
        end

        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    // State registers; reset leaves master 0 with first priority
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ar_full_q <= 1'b0;
            ar_addr_q <= '0;
            last_q    <= IW'(N_MST - 1);
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            for (int i = 0; i < MAX_OUT; i++) begin
                route_q[i] <= '0;
            end
        end else begin
            ar_full_q <= ar_full_d;
            ar_addr_q <= ar_addr_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            route_q   <= route_d;
        end
    end

endmodule
